banked_array: RTL

BANKED_ARRAY -- requirements
Module: banked_array

---
 rtl/banked_array.sv | 110 +++++++++++
 1 files changed

// File: rtl/banked_array.sv
// Set-associative data/valid array with byte-masked writes, 1-cycle registered reads with
// same-cycle write forwarding, and a flush sweep that invalidates one set per cycle.
module banked_array #(
  parameter int unsigned s_index  = 3,
  parameter int unsigned width    = 32,
  parameter int unsigned num_ways = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      read,
  input  logic [s_index-1:0]        rindex,
  input  logic                      load,
  input  logic [s_index-1:0]        windex,
  input  logic [num_ways-1:0]       wway,
  input  logic [width/8-1:0]        wmask,
  input  logic [width-1:0]          datain,
  input  logic                      flush,
  output logic [num_ways*width-1:0] dataout,
  output logic [num_ways-1:0]       validout,
  output logic                      busy
);

  localparam int unsigned num_sets = 2 ** s_index;
  localparam int unsigned nbytes   = width / 8;
  localparam logic [s_index-1:0] last_set = '1;

  typedef enum logic {StIdle, StSweep} state_e;

  state_e                                      state_q, state_d;
  logic [s_index-1:0]                          cnt_q, cnt_d;
  logic [num_sets-1:0][num_ways-1:0][width-1:0] data_q, data_d;
  logic [num_sets-1:0][num_ways-1:0]           valid_q, valid_d;
  logic [num_ways*width-1:0]                   dataout_d;
  logic [num_ways-1:0]                         validout_d;
  logic                                        do_write, do_read;

  assign busy = (state_q == StSweep);
  // A load coinciding with the flush request is dropped; the read still sees pre-flush data.
  assign do_write = load & ~busy & ~flush;
  assign do_read  = read & ~busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (flush) begin
          state_d = StSweep;
          cnt_d   = '0;
        end
      end
      StSweep: begin
        if (cnt_q == last_set) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (do_write) begin
      for (int unsigned w = 0; w < num_ways; w++) begin
        if (wway[w]) begin
          for (int unsigned b = 0; b < nbytes; b++) begin
            if (wmask[b]) data_d[windex][w][8*b +: 8] = datain[8*b +: 8];
          end
          valid_d[windex][w] = 1'b1;
        end
      end
    end
    if (state_q == StSweep) valid_d[cnt_q] = '0;
  end

  // Reading from the next-state array gives write-to-read forwarding for free.
  always_comb begin
    dataout_d  = dataout;
    validout_d = validout;
    if (do_read) begin
      for (int unsigned w = 0; w < num_ways; w++) begin
        dataout_d[w*width +: width] = data_d[rindex][w];
      end
      validout_d = valid_d[rindex];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= '0;
      dataout  <= '0;
      validout <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      dataout  <= dataout_d;
      validout <= validout_d;
    end
  end

endmodule
